// File: rtl/biu_arbiter_if.sv
// Wishbone master/slave bundle used on each side of biu_arbiter.
//   cyc/stb/cab/we/sel/adr/wdat : request from the bus master
//   rdat/ack/err                : response from the bus slave
// The master modport belongs to whoever drives the request. The slave modport
// belongs to whoever answers it.
interface biu_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cyc;
    logic          stb;
    logic          cab;
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic          ack;
    logic          err;

    modport master (
        output cyc, stb, cab, we, sel, adr, wdat,
        input  rdat, ack, err
    );

    modport slave (
        input  cyc, stb, cab, we, sel, adr, wdat,
        output rdat, ack, err
    );
endinterface

// File: rtl/biu_arbiter.sv
// Two-master Wishbone arbiter in front of the BIU. Master 0 is the I-cache
// refill and master 1 is the D-cache refill/writeback. A master keeps the grant
// for its whole burst, from cyc rising to cyc falling. Arbitration is
// round-robin. A watchdog aborts a burst whose slave stops acknowledging.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   m0, m1     : cache-side buses; the arbiter acts as their slave
//   wb         : BIU-side bus; the arbiter acts as its master
//   gnt        : one-hot current owner, taken from the state register
//                (00 means no owner)
module biu_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    biu_arbiter_if.slave  m0,
    biu_arbiter_if.slave  m1,
    biu_arbiter_if.master wb,
    output logic [1:0]    gnt
);
    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          pri, pri_nxt;            // 0: m0 preferred on a tie
    logic          abort_id, abort_id_nxt;  // master whose burst was aborted
    logic [CW-1:0] wd_cnt, wd_cnt_nxt;
    logic          wd_fire;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pri      <= 1'b0;
            abort_id <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            pri      <= pri_nxt;
            abort_id <= abort_id_nxt;
            wd_cnt   <= wd_cnt_nxt;
        end
    end

    // Next-state, priority and watchdog update
    always_comb begin
        state_nxt    = state;
        pri_nxt      = pri;
        abort_id_nxt = abort_id;
        wd_cnt_nxt   = wd_cnt;
        case (state)
            IDLE: begin
                wd_cnt_nxt = '0;
                if (m0.cyc && m1.cyc) begin
                    state_nxt = pri ? GNT1 : GNT0;
                end else if (m0.cyc) begin
                    state_nxt = GNT0;
                end else if (m1.cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!((state == GNT1) ? m1.cyc : m0.cyc)) begin
                    state_nxt  = IDLE;
                    pri_nxt    = (state == GNT0);
                    wd_cnt_nxt = '0;
                end else if (wd_fire) begin
                    state_nxt    = ABORT;
                    abort_id_nxt = (state == GNT1);
                    wd_cnt_nxt   = '0;
                end else if (wb.ack || wb.err) begin
                    // A response on the expiry cycle clears the count, so the burst is not aborted
                    wd_cnt_nxt = '0;
                end else if (wb.stb) begin
                    wd_cnt_nxt = wd_cnt + CW'(1);
                end
            end
            ABORT: begin
                wd_cnt_nxt = '0;
                if (!(abort_id ? m1.cyc : m0.cyc)) begin
                    state_nxt = IDLE;
                    pri_nxt   = ~abort_id;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus mux, response steering and watchdog pulse
    always_comb begin
        wb.cyc  = 1'b0;
        wb.stb  = 1'b0;
        wb.cab  = 1'b0;
        wb.we   = 1'b0;
        wb.sel  = '0;
        wb.adr  = '0;
        wb.wdat = '0;
        gnt     = 2'b00;
        // Read data goes to both masters; only ack makes it meaningful to a master
        m0.rdat = wb.rdat;
        m1.rdat = wb.rdat;
        case (state)
            GNT0: begin
                gnt     = 2'b01;
                wb.cyc  = m0.cyc;
                wb.stb  = m0.stb & m0.cyc;
                wb.cab  = m0.cab;
                wb.we   = m0.we;
                wb.sel  = m0.sel;
                wb.adr  = m0.adr;
                wb.wdat = m0.wdat;
            end
            GNT1: begin
                gnt     = 2'b10;
                wb.cyc  = m1.cyc;
                wb.stb  = m1.stb & m1.cyc;
                wb.cab  = m1.cab;
                wb.we   = m1.we;
                wb.sel  = m1.sel;
                wb.adr  = m1.adr;
                wb.wdat = m1.wdat;
            end
            default: ;
        endcase
        wd_fire = (gnt != 2'b00) && wb.stb && !wb.ack && !wb.err && (wd_cnt == CNT_LAST);
        m0.ack  = gnt[0] & wb.ack;
        m0.err  = gnt[0] & (wb.err | wd_fire);
        m1.ack  = gnt[1] & wb.ack;
        m1.err  = gnt[1] & (wb.err | wd_fire);
    end
endmodule

// File: tb/tb_biu_arbiter.sv
// Scoreboard bench for biu_arbiter. Two instances receive the same stimulus:
// dut_a uses the default TIMEOUT of 256 and dut_b uses a TIMEOUT of 4.
// Expected outputs come from a reference model of the bus ownership.
module tb_biu_arbiter;
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        cab;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } req_t;

    typedef struct packed {
        logic [1:0]  gnt;
        req_t        bus;
        logic [3:0]  resp;   // {m1_err, m1_ack, m0_err, m0_ack}
        logic [63:0] rdat;   // {m0_dat, m1_dat}
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic        clk;
    logic        rst_n;
    req_t        req [2];
    logic        b_ack, b_err;
    logic [31:0] b_rdat;
    logic [1:0]  gnt_a, gnt_b;
    exp_t        got_a, got_b;

    int checks = 0;
    int errors = 0;
    pair_t q[$];

    // Reference model state, one entry per DUT
    int own   [2];
    bit abrt  [2];
    int pri   [2];
    int stall [2];
    int to_lim[2] = '{256, 4};

    biu_arbiter_if #(.AW(32), .DW(32)) m0a(), m1a(), wba(), m0b(), m1b(), wbb();

    biu_arbiter #(.TIMEOUT(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .m0(m0a), .m1(m1a), .wb(wba), .gnt(gnt_a)
    );
    biu_arbiter #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .m0(m0b), .m1(m1b), .wb(wbb), .gnt(gnt_b)
    );

    assign {m0a.cyc, m0a.stb, m0a.cab, m0a.we, m0a.sel, m0a.adr, m0a.wdat} = req[0];
    assign {m1a.cyc, m1a.stb, m1a.cab, m1a.we, m1a.sel, m1a.adr, m1a.wdat} = req[1];
    assign {m0b.cyc, m0b.stb, m0b.cab, m0b.we, m0b.sel, m0b.adr, m0b.wdat} = req[0];
    assign {m1b.cyc, m1b.stb, m1b.cab, m1b.we, m1b.sel, m1b.adr, m1b.wdat} = req[1];
    assign {wba.rdat, wba.ack, wba.err} = {b_rdat, b_ack, b_err};
    assign {wbb.rdat, wbb.ack, wbb.err} = {b_rdat, b_ack, b_err};

    assign got_a = {gnt_a, wba.cyc, wba.stb, wba.cab, wba.we, wba.sel, wba.adr, wba.wdat,
                    m1a.err, m1a.ack, m0a.err, m0a.ack, m0a.rdat, m1a.rdat};
    assign got_b = {gnt_b, wbb.cyc, wbb.stb, wbb.cab, wbb.we, wbb.sel, wbb.adr, wbb.wdat,
                    m1b.err, m1b.ack, m0b.err, m0b.ack, m0b.rdat, m1b.rdat};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            own[d] = -1; abrt[d] = 0; pri[d] = 0; stall[d] = 0;
        end
    end

    // Outputs expected this cycle, given the owner and the current inputs
    function automatic exp_t model_out(input int d, output bit fire);
        exp_t e;
        int   x;
        e      = '0;
        fire   = 1'b0;
        e.rdat = {b_rdat, b_rdat};
        if (own[d] >= 0 && !abrt[d]) begin
            x          = own[d];
            e.gnt      = (x == 0) ? 2'b01 : 2'b10;
            e.bus      = req[x];
            e.bus.stb  = req[x].stb & req[x].cyc;
            fire       = req[x].cyc && req[x].stb && !b_ack && !b_err && (stall[d] == to_lim[d] - 1);
            if (x == 0) begin
                e.resp[0] = b_ack;
                e.resp[1] = b_err | fire;
            end else begin
                e.resp[2] = b_ack;
                e.resp[3] = b_err | fire;
            end
        end
        return e;
    endfunction

    // Ownership bookkeeping at the clock edge
    function automatic void model_step(input int d, input bit fire);
        int x;
        x = own[d];
        if (!rst_n) begin
            own[d] = -1; abrt[d] = 0; pri[d] = 0; stall[d] = 0;
        end else if (x < 0) begin
            stall[d] = 0;
            if (req[0].cyc && req[1].cyc) own[d] = pri[d];
            else if (req[0].cyc)          own[d] = 0;
            else if (req[1].cyc)          own[d] = 1;
        end else if (abrt[d]) begin
            if (!req[x].cyc) begin
                pri[d] = 1 - x; own[d] = -1; abrt[d] = 0;
            end
        end else if (!req[x].cyc) begin
            pri[d] = 1 - x; own[d] = -1;
        end else if (fire) begin
            abrt[d] = 1;
        end else if (b_ack || b_err) begin
            stall[d] = 0;
        end else if (req[x].stb) begin
            stall[d] = stall[d] + 1;
        end
    endfunction

    // Records the expected outputs for the current inputs, then advances one clock
    task automatic step();
        pair_t p;
        bit    f0, f1;
        p.a = model_out(0, f0);
        p.b = model_out(1, f1);
        q.push_back(p);
        @(posedge clk);
        model_step(0, f0);
        model_step(1, f1);
        #1;
    endtask

    task automatic chk(input int d, input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL dut%0d %s t=%0t got %h expected %h", d, name, $time, got, exp);
        end
    endtask

    task automatic cmp(input int d, input exp_t g, input exp_t e);
        chk(d, "gnt",  72'(g.gnt),  72'(e.gnt));
        chk(d, "bus",  72'(g.bus),  72'(e.bus));
        chk(d, "resp", 72'(g.resp), 72'(e.resp));
        chk(d, "rdat", 72'(g.rdat), 72'(e.rdat));
    endtask

    // Monitor: compares the outputs against the queued expectations mid-cycle
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                p = q.pop_front();
                cmp(0, got_a, p.a);
                cmp(1, got_b, p.b);
            end
        end
    end

    task automatic idle_all();
        req[0] = '0;
        req[1] = '0;
        b_ack  = 1'b0;
        b_err  = 1'b0;
    endtask

    initial begin
        int n[2];
        int hold[2];
        int x;
        rst_n  = 1'b0;
        b_rdat = '0;
        idle_all();
        @(posedge clk);
        #1;

        // Reset held while both masters request, then release
        req[0].cyc = 1'b1; req[0].stb = 1'b1;
        req[1].cyc = 1'b1; req[1].stb = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        idle_all();
        repeat (2) step();

        // Single 8-beat m0 burst at 0x1000
        req[0] = '{cyc: 1'b1, stb: 1'b1, cab: 1'b1, we: 1'b0, sel: 4'hf, adr: 32'h1000, dat: 32'h0};
        step();
        for (int i = 0; i < 16; i++) begin
            b_ack  = (i % 2 == 1);
            b_rdat = $urandom;
            step();
        end
        b_ack = 1'b0;
        req[0].cyc = 1'b0;
        repeat (2) step();

        // Contention: both request continuously; each drops cyc after 8 acks
        n = '{0, 0};
        hold = '{0, 0};
        for (int k = 0; k < 2; k++) begin
            req[k] = '{cyc: 1'b1, stb: 1'b1, cab: 1'b1, we: 1'(k), sel: 4'hf,
                       adr: 32'h2000 + 32'(k), dat: 32'hA0 + 32'(k)};
        end
        for (int i = 0; i < 90; i++) begin
            for (int k = 0; k < 2; k++) begin
                req[k].cyc = (hold[k] == 0);
                if (hold[k] > 0) hold[k]--;
            end
            x = own[0];
            b_ack = (x >= 0) && !abrt[0] && req[(x < 0) ? 0 : x].cyc;
            step();
            if (b_ack) begin
                n[x]++;
                if (n[x] == 8) begin
                    n[x] = 0;
                    hold[x] = 1;
                end
            end
        end
        idle_all();
        repeat (2) step();

        // Watchdog: m1 strobes with no ack; m0 starts waiting part-way through
        req[1] = '{cyc: 1'b1, stb: 1'b1, cab: 1'b0, we: 1'b1, sel: 4'h3, adr: 32'h3000, dat: 32'h55};
        for (int i = 0; i < 270; i++) begin
            if (i == 100) begin
                req[0].cyc = 1'b1;
                req[0].stb = 1'b1;
            end
            step();
        end
        req[1].cyc = 1'b0;
        repeat (4) step();
        idle_all();
        repeat (2) step();

        // Ack arriving on every 4th stalled cycle of an m0 burst
        req[0] = '{cyc: 1'b1, stb: 1'b1, cab: 1'b1, we: 1'b0, sel: 4'hf, adr: 32'h4000, dat: 32'h0};
        step();
        for (int i = 0; i < 16; i++) begin
            b_ack = (i % 4 == 3);
            step();
        end
        idle_all();
        repeat (2) step();

        // Stray responses with no owner
        b_ack = 1'b1; b_err = 1'b1;
        repeat (2) step();
        idle_all();
        step();

        // Reset during beat 3 of an m0 burst
        req[0] = '{cyc: 1'b1, stb: 1'b1, cab: 1'b1, we: 1'b0, sel: 4'hf, adr: 32'h5000, dat: 32'h0};
        step();
        b_ack = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        b_ack = 1'b0;
        repeat (2) step();
        idle_all();
        repeat (2) step();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (req[k].cyc) req[k].cyc = ($urandom % 10 != 0);
                else            req[k].cyc = ($urandom % 4 == 0);
                req[k].stb = ($urandom % 4 != 0);
                req[k].cab = 1'($urandom);
                req[k].we  = 1'($urandom);
                req[k].sel = 4'($urandom);
                req[k].adr = $urandom;
                req[k].dat = $urandom;
            end
            b_ack  = ($urandom % 100 < 45);
            b_err  = ($urandom % 100 < 4);
            b_rdat = $urandom;
            rst_n  = ($urandom % 600 != 0);
            step();
        end
        rst_n = 1'b1;
        idle_all();
        step();

        @(negedge clk);
        #1;
        chk(0, "drain", 72'(q.size()), 72'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
